// File: rtl/trace_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : trace_frame_rx
// Purpose  : Receive side of the sensor-trace UART link. Reassembles one
//            capture frame from the uart_rx byte stream: 16 PT, 16 KEY and
//            16 CT bytes (MSB byte first), then SAMPLES sensor bytes that are
//            stored in a local buffer. Checks the start flag and searches for
//            the end marker, and aborts the frame on an inter-byte timeout.
// Ports    : clk, rstn          - clock, asynchronous active-low reset
//            rx_dv, rx_byte     - 1-cycle byte strobe and data from uart_rx
//            pt, key, ct        - 128-bit fields of the last completed frame
//            frame_done         - 1-cycle pulse, frame fully received
//            frame_ok, err_code - result (0 ok, 1 timeout, 2 bad start,
//                                 3 no end marker), held until next result
//            marker_idx         - index of first END_FLAG sample (0 if none)
//            busy               - frame in progress
//            rd_addr, rd_data   - sample buffer read port, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module trace_frame_rx #(
  parameter int         SAMPLES    = 512,
  parameter int         TIMEOUT    = 100000,
  parameter logic [7:0] START_FLAG = 8'd250,
  parameter logic [7:0] END_FLAG   = 8'd255,
  localparam int        AW         = $clog2(SAMPLES)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_dv,
  input  logic [7:0]    rx_byte,
  output logic [127:0]  pt,
  output logic [127:0]  key,
  output logic [127:0]  ct,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [1:0]    err_code,
  output logic [AW-1:0] marker_idx,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [5:0]    C_HDR_LAST = 6'd47;
  localparam logic [AW-1:0] C_SEN_LAST = AW'(SAMPLES - 1);
  localparam logic [TW-1:0] C_TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [5:0]     r_hidx;
  logic [AW-1:0]  r_sidx;
  logic [TW-1:0]  r_tcnt;
  // Header bytes shift in from the bottom, so after 48 bytes the first
  // received byte sits at the top: PT in [383:256], KEY, then CT in [127:0].
  logic [383:0]   r_shadow;
  logic           r_bad_start;
  logic           r_marker_found;
  logic [AW-1:0]  r_marker_idx_sh;

  logic [7:0]     r_mem [SAMPLES];
  logic [7:0]     r_rd_data;

  logic [127:0]   r_pt, r_key, r_ct;
  logic           r_frame_done, r_frame_ok;
  logic [1:0]     r_err_code;
  logic [AW-1:0]  r_marker_idx;

  logic           w_in_frame;
  logic           w_timeout;
  logic           w_start;
  logic           w_hdr_last;
  logic           w_sen_last;
  logic           w_we;
  logic [1:0]     w_err;

  assign w_in_frame = (r_state == ST_HDR) || (r_state == ST_SEN);
  // A byte arriving on the last idle cycle still counts, so abort needs !rx_dv.
  assign w_timeout  = w_in_frame && !rx_dv && (r_tcnt == C_TO_LAST);
  // A byte in DONE opens the next frame exactly like a byte in IDLE.
  assign w_start    = rx_dv && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_hdr_last = (r_state == ST_HDR) && rx_dv && (r_hidx == C_HDR_LAST);
  assign w_sen_last = (r_state == ST_SEN) && rx_dv && (r_sidx == C_SEN_LAST);
  assign w_we       = (r_state == ST_SEN) && rx_dv;
  assign w_err      = r_bad_start     ? 2'd2 :
                      !r_marker_found ? 2'd3 : 2'd0;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (rx_dv) w_state_nxt = ST_HDR;
      ST_HDR: begin
        if (w_timeout)       w_state_nxt = ST_IDLE;
        else if (w_hdr_last) w_state_nxt = ST_SEN;
      end
      ST_SEN: begin
        if (w_timeout)       w_state_nxt = ST_IDLE;
        else if (w_sen_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = rx_dv ? ST_HDR : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hidx          <= '0;
      r_sidx          <= '0;
      r_tcnt          <= '0;
      r_shadow        <= '0;
      r_bad_start     <= 1'b0;
      r_marker_found  <= 1'b0;
      r_marker_idx_sh <= '0;
      r_pt            <= '0;
      r_key           <= '0;
      r_ct            <= '0;
      r_frame_done    <= 1'b0;
      r_frame_ok      <= 1'b0;
      r_err_code      <= 2'd0;
      r_marker_idx    <= '0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_in_frame && !rx_dv && !w_timeout) r_tcnt <= r_tcnt + 1'b1;
      else                                    r_tcnt <= '0;

      if (r_state == ST_DONE) begin
        r_pt         <= r_shadow[383:256];
        r_key        <= r_shadow[255:128];
        r_ct         <= r_shadow[127:0];
        r_marker_idx <= r_marker_idx_sh;
        r_err_code   <= w_err;
        r_frame_ok   <= (w_err == 2'd0);
        r_frame_done <= 1'b1;
      end

      if (w_start) begin
        r_shadow        <= {r_shadow[375:0], rx_byte};
        r_hidx          <= 6'd1;
        r_bad_start     <= 1'b0;
        r_marker_found  <= 1'b0;
        r_marker_idx_sh <= '0;
      end

      if ((r_state == ST_HDR) && rx_dv) begin
        r_shadow <= {r_shadow[375:0], rx_byte};
        if (w_hdr_last) begin
          r_hidx <= '0;
          r_sidx <= '0;
        end else begin
          r_hidx <= r_hidx + 1'b1;
        end
      end

      if (w_we) begin
        // sidx wraps to 0 after the last sample, ready for the next frame.
        r_sidx <= r_sidx + 1'b1;
        if ((r_sidx == '0) && (rx_byte != START_FLAG))
          r_bad_start <= 1'b1;
        if ((r_sidx != '0) && (rx_byte == END_FLAG) && !r_marker_found) begin
          r_marker_found  <= 1'b1;
          r_marker_idx_sh <= r_sidx;
        end
      end

      if (w_timeout) begin
        r_err_code      <= 2'd1;
        r_frame_ok      <= 1'b0;
        r_hidx          <= '0;
        r_sidx          <= '0;
        r_bad_start     <= 1'b0;
        r_marker_found  <= 1'b0;
        r_marker_idx_sh <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample buffer: contents are not reset. Read-before-write on a collision.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_sidx] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_data <= 8'd0;
    else       r_rd_data <= r_mem[rd_addr];
  end

  assign pt         = r_pt;
  assign key        = r_key;
  assign ct         = r_ct;
  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;
  assign err_code   = r_err_code;
  assign marker_idx = r_marker_idx;
  assign busy       = (r_state != ST_IDLE);
  assign rd_data    = r_rd_data;

endmodule
`default_nettype wire
